// File: rtl/bound_flasher_param.sv
`default_nettype none
// ---------------------------------------------------------------------------
// bound_flasher_param: tick-paced three-phase lamp-bar bounce with flick kickback.
// Optional all-on BLINK frame when BOUND_FLASHER_BLINK_EN is defined. Rev 1.0
// ---------------------------------------------------------------------------
module bound_flasher_param #(
  parameter int N_LAMPS  = 16,
  parameter int TICK_DIV = 200,
  parameter int HI1      = 6,
  parameter int HI2      = 11,
  parameter int LO2      = 5
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           flick,
  output logic [N_LAMPS-1:0]             lamps,
  output logic [$clog2(N_LAMPS+1)-1:0]   level,
  output logic                           busy,
  output logic                           done
);

  localparam int LW = $clog2(N_LAMPS + 1);
  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [LW-1:0] ONE_L  = LW'(1);
  localparam logic [LW-1:0] ZERO_L = '0;
  localparam logic [LW-1:0] HI1_L  = LW'(HI1);
  localparam logic [LW-1:0] HI2_L  = LW'(HI2);
  localparam logic [LW-1:0] LO2_L  = LW'(LO2);
  localparam logic [LW-1:0] TOP_L  = LW'(N_LAMPS);
  localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_UP1   = 3'd1,
    S_DOWN1 = 3'd2,
    S_UP2   = 3'd3,
    S_DOWN2 = 3'd4,
    S_UP3   = 3'd5,
    S_DOWN3 = 3'd6
`ifdef BOUND_FLASHER_BLINK_EN
    , S_BLINK = 3'd7
`endif
  } state_t;

  state_t          state_q, state_d;
  logic [LW-1:0]   level_q, level_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            done_q, done_d;

  logic            tick;
  logic            kick;
  logic            blink_on;
  logic [N_LAMPS-1:0] bar;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      level_q <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  assign tick = (cnt_q == CNT_LAST);
  // Kickback only matters on UP2/UP3 ticks; the case arms below gate it.
  assign kick = flick && ((level_q == HI1_L) || (level_q == HI2_L));

  always_comb begin
    state_d = state_q;
    level_d = level_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    if (state_q == S_IDLE) begin
      cnt_d   = '0;
      level_d = '0;
      if (flick) state_d = S_UP1;
    end else begin
      cnt_d = tick ? '0 : cnt_q + CNT_ONE;
      if (tick) begin
        case (state_q)
          S_UP1: begin
            if (level_q == HI1_L) begin
              state_d = S_DOWN1;
              level_d = level_q - ONE_L;
            end else begin
              level_d = level_q + ONE_L;
            end
          end
          S_DOWN1: begin
            if (level_q == ZERO_L) begin
              state_d = S_UP2;
              level_d = level_q + ONE_L;
            end else begin
              level_d = level_q - ONE_L;
            end
          end
          S_UP2: begin
            if (kick) begin
              state_d = S_DOWN1;
              level_d = level_q - ONE_L;
            end else if (level_q == HI2_L) begin
              state_d = S_DOWN2;
              level_d = level_q - ONE_L;
            end else begin
              level_d = level_q + ONE_L;
            end
          end
          S_DOWN2: begin
            if (level_q == LO2_L) begin
              state_d = S_UP3;
              level_d = level_q + ONE_L;
            end else begin
              level_d = level_q - ONE_L;
            end
          end
          S_UP3: begin
            if (kick) begin
              state_d = S_DOWN2;
              level_d = level_q - ONE_L;
            end else if (level_q == TOP_L) begin
              state_d = S_DOWN3;
              level_d = level_q - ONE_L;
            end else begin
              level_d = level_q + ONE_L;
            end
          end
          S_DOWN3: begin
            if (level_q == ZERO_L) begin
`ifdef BOUND_FLASHER_BLINK_EN
              state_d = S_BLINK;
`else
              state_d = S_IDLE;
              done_d  = 1'b1;
`endif
            end else begin
              level_d = level_q - ONE_L;
            end
          end
`ifdef BOUND_FLASHER_BLINK_EN
          S_BLINK: begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
`endif
          default: begin
            state_d = S_IDLE;
            level_d = '0;
          end
        endcase
      end
    end
  end

  for (genvar i = 0; i < N_LAMPS; i++) begin : g_lamps
    assign bar[i] = (level_q > LW'(i));
  end

`ifdef BOUND_FLASHER_BLINK_EN
  assign blink_on = (state_q == S_BLINK);
`else
  assign blink_on = 1'b0;
`endif

  assign lamps = blink_on ? {N_LAMPS{1'b1}} : bar;
  assign level = level_q;
  assign busy  = (state_q != S_IDLE);
  assign done  = done_q;

endmodule
`default_nettype wire

// File: tb/tb_bound_flasher_param.sv
`default_nettype none
// tb_bound_flasher_param: random and directed flick stimulus on TICK_DIV=4 and
// TICK_DIV=1 instances, compared each cycle against a table-driven phase model.
module tb_bound_flasher_param;

  localparam int N   = 16;
  localparam int HI1 = 6;
  localparam int HI2 = 11;
  localparam int LO2 = 5;
`ifdef BOUND_FLASHER_BLINK_EN
  localparam bit BLINK = 1'b1;
  localparam int RUN_CYCLES = 232;
`else
  localparam bit BLINK = 1'b0;
  localparam int RUN_CYCLES = 228;
`endif

  logic clk = 1'b0;
  logic rst;
  logic flick;
  logic [15:0] lamps4, lamps1;
  logic [4:0]  level4, level1;
  logic        busy4, busy1, done4, done1;

  always #5 clk = ~clk;

  bound_flasher_param #(.N_LAMPS(N), .TICK_DIV(4), .HI1(HI1), .HI2(HI2), .LO2(LO2)) dut4 (
    .clk(clk), .rst(rst), .flick(flick),
    .lamps(lamps4), .level(level4), .busy(busy4), .done(done4));

  bound_flasher_param #(.N_LAMPS(N), .TICK_DIV(1), .HI1(HI1), .HI2(HI2), .LO2(LO2)) dut1 (
    .clk(clk), .rst(rst), .flick(flick),
    .lamps(lamps1), .level(level1), .busy(busy1), .done(done1));

  // Phase 0 = idle, 1..6 = sweeps (odd rising, even falling), 7 = blink.
  typedef struct {
    int p;
    int l;
    int cnt;
    bit done;
  } m_t;

  m_t m4, m1;
  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
  endtask

  function automatic m_t mreset();
    m_t s;
    s.p = 0; s.l = 0; s.cnt = 0; s.done = 1'b0;
    return s;
  endfunction

  function automatic int top_of(int p);
    return (p == 1) ? HI1 : (p == 3) ? HI2 : N;
  endfunction

  function automatic int bot_of(int p);
    return (p == 4) ? LO2 : 0;
  endfunction

  function automatic m_t mstep(m_t s, bit f, bit r, int div);
    m_t n;
    if (r) return mreset();
    n = s;
    n.done = 1'b0;
    if (s.p == 0) begin
      n.cnt = 0; n.l = 0;
      if (f) n.p = 1;
      return n;
    end
    if (s.cnt != div - 1) begin
      n.cnt = s.cnt + 1;
      return n;
    end
    n.cnt = 0;
    if (s.p == 7) begin
      n.p = 0; n.done = 1'b1;
    end else if (s.p % 2 == 1) begin
      if ((s.p == 3 || s.p == 5) && f && (s.l == HI1 || s.l == HI2)) begin
        n.p = s.p - 1; n.l = s.l - 1;
      end else if (s.l == top_of(s.p)) begin
        n.p = s.p + 1; n.l = s.l - 1;
      end else begin
        n.l = s.l + 1;
      end
    end else begin
      if (s.l != bot_of(s.p)) n.l = s.l - 1;
      else if (s.p != 6) begin n.p = s.p + 1; n.l = s.l + 1; end
      else if (BLINK) n.p = 7;
      else begin n.p = 0; n.done = 1'b1; end
    end
    return n;
  endfunction

  function automatic logic [31:0] exp_lamps(m_t s);
    logic [31:0] one;
    one = 32'd1;
    if (s.p == 7) return 32'h0000_FFFF;
    return (one << s.l) - one;
  endfunction

  task automatic compare_all();
    check("lamps4", {16'h0, lamps4}, exp_lamps(m4));
    check("level4", 32'(level4), 32'(m4.l));
    check("busy4",  32'(busy4),  32'(m4.p != 0));
    check("done4",  32'(done4),  32'(m4.done));
    check("lamps1", {16'h0, lamps1}, exp_lamps(m1));
    check("level1", 32'(level1), 32'(m1.l));
    check("busy1",  32'(busy1),  32'(m1.p != 0));
    check("done1",  32'(done1),  32'(m1.done));
  endtask

  task automatic step();
    m4 = mstep(m4, flick, rst, 4);
    m1 = mstep(m1, flick, rst, 1);
    @(posedge clk);
    #1;
    cyc++;
    compare_all();
  endtask

  task automatic wait_idle(input int budget);
    int k;
    k = 0;
    flick = 1'b0;
    while ((m4.p != 0 || m1.p != 0) && k < budget) begin
      step();
      k++;
    end
    check("idle_timeout", 32'(k < budget), 32'd1);
  endtask

  initial begin
    int start;
    int k;
    bit seen_done;
    bit all_ones;
    bit kicked;

    m4 = mreset();
    m1 = mreset();
    rst = 1'b1;
    flick = 1'b0;
    step();
    step();
    rst = 1'b0;

    // Quiet idle after reset
    repeat (100) step();

    // Single flick pulse: full no-flick run
    flick = 1'b1;
    step();
    start = cyc;
    flick = 1'b0;
    seen_done = 1'b0;
    all_ones = 1'b0;
    k = 0;
    while (!seen_done && k < 400) begin
      step();
      k++;
      if (lamps4 == 16'hFFFF && level4 != 5'd16) all_ones = 1'b1;
      if (done4) seen_done = 1'b1;
    end
    check("run_length", 32'(cyc - start), 32'(RUN_CYCLES));
    check("blink_frame", 32'(all_ones), 32'(BLINK));
    wait_idle(50);

    // Flick held high: kickbacks at HI1 in UP2, then release
    flick = 1'b1;
    repeat (300) step();
    flick = 1'b0;
    wait_idle(400);

    // UP3 kick at HI2: off-tick pulse first (ignored), then on-tick pulse
    flick = 1'b1;
    step();
    flick = 1'b0;
    kicked = 1'b0;
    k = 0;
    while ((!kicked || m4.p != 0) && k < 600) begin
      flick = (m4.p == 5 && m4.l == HI2 && !kicked && (m4.cnt == 1 || m4.cnt == 3));
      step();
      if (flick && m4.cnt == 0) begin
        kicked = 1'b1;
        check("up3_kick_level", 32'(level4), 32'(HI2 - 1));
      end
      k++;
    end
    flick = 1'b0;
    check("up3_kick_seen", 32'(kicked), 32'd1);
    wait_idle(400);

    // Asynchronous reset mid-sweep at level 9
    flick = 1'b1;
    step();
    flick = 1'b0;
    k = 0;
    while (m4.l != 9 && k < 400) begin
      step();
      k++;
    end
    check("reach_level9", 32'(level4), 32'd9);
    #2 rst = 1'b1;
    #1;
    m4 = mreset();
    m1 = mreset();
    check("async_lamps", {16'h0, lamps4}, 32'd0);
    check("async_busy", 32'(busy4), 32'd0);
    check("async_done", 32'(done4), 32'd0);
    step();
    rst = 1'b0;
    repeat (3) step();
    flick = 1'b1;
    step();
    flick = 1'b0;
    repeat (20) step();
    wait_idle(400);

    // Randomised flick traffic
    repeat (2000) begin
      flick = ($urandom_range(0, 7) == 0);
      step();
    end
    wait_idle(400);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/bound_flasher_param.md
# bound_flasher_param

Parametrised lamp-bar sequencer for the LED front panel. It drives an N-lamp thermometer bar through a fixed three-phase bounce (up/down to HI1, up/down between 0, HI2 and LO2, up to full and down to 0), then an optional all-on flash. A flick input forces kickbacks at HI1 and HI2. Sits directly between the debounced flick input and the lamp driver pins, with a programmable step rate from an internal tick divider.

## Interface
- N_LAMPS, 16: lamp count; bar level L ranges 0..N_LAMPS
- TICK_DIV, 200: clk cycles per step (≥1)
- HI1, 6: first bounce top and flick kick point
- HI2, 11: second bounce top and flick kick point
- LO2, 5: bottom of the second down-sweep
- Legal only with 1 ≤ HI1 < HI2 < N_LAMPS and 1 ≤ LO2 < HI2
- clk  in  1  single clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- flick  in  1  synchronous, level-sampled
- lamps  out  N_LAMPS  thermometer bar, lamps[i] = (i < L); all ones in BLINK
- level  out  $clog2(N_LAMPS+1)  current L
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse on return to IDLE

## Operation
- Registers: state, L, tick counter cnt (0..TICK_DIV-1).
- A tick is the edge where cnt == TICK_DIV-1. cnt then wraps to 0. cnt runs in all non-IDLE states. All L and state changes outside IDLE happen only on ticks.
- IDLE: L=0, cnt=0. If flick=1 on any edge, go to UP1 with cnt=0.
- UP1: on a tick, L==HI1 goes to DOWN1 with L-1. Otherwise L+1.
- DOWN1: on a tick, L==0 goes to UP2 with L+1. Otherwise L-1.
- UP2: on a tick, evaluate in priority order:
  - flick=1 and (L==HI1 or L==HI2): go to DOWN1 with L-1 (kickback).
  - L==HI2: go to DOWN2 with L-1.
  - Otherwise L+1.
- DOWN2: on a tick, L==LO2 goes to UP3 with L+1. Otherwise L-1.
- UP3: on a tick, evaluate in priority order:
  - flick=1 and (L==HI1 or L==HI2): go to DOWN2 with L-1.
  - L==N_LAMPS: go to DOWN3 with L-1.
  - Otherwise L+1.
- DOWN3: on a tick, L==0 goes to BLINK (macro on) or IDLE with done=1 (macro off). Otherwise L-1.
- BLINK: lamps all ones, L stays 0. On a tick, go to IDLE with done=1.
- flick is ignored outside IDLE except on ticks in UP2/UP3 with L at HI1 or HI2. flick is ignored in UP1, DOWN*, and BLINK.
- L never leaves 0..N_LAMPS. Parameter constraints make over- and underflow unreachable.

## Timing
- Reset values: state=IDLE, L=0, cnt=0, lamps=0, level=0, busy=0, done=0.
- rst is asserted asynchronously and clears all registers immediately, mid-sweep included. The first action after deassertion is IDLE sampling flick.
- flick=1 at edge k in IDLE gives busy=1 after edge k. The first step, lamps=1, follows edge k+TICK_DIV.
- Every lamp pattern, including the tops, the bottoms and 0, is held exactly TICK_DIV cycles.
- Outputs are registered or decoded from registers only, with no flick-to-lamps combinational path.
- done is high for the single cycle after the edge that enters IDLE. It is not asserted by reset.
- A full no-flick run is 58 ticks from UP1 entry to IDLE with BLINK, and 57 ticks without.

## Configuration
- BOUND_FLASHER_BLINK_EN defined: BLINK state is present. After DOWN3 reaches 0, all lamps light for one tick period, then the block returns to IDLE.
- BOUND_FLASHER_BLINK_EN undefined: BLINK state and logic are removed. DOWN3 at L==0 on a tick goes straight to IDLE with done=1. lamps is never all ones except at L==N_LAMPS.

## Test plan
Defaults N_LAMPS=16, HI1=6, HI2=11, LO2=5, TICK_DIV=4 unless noted.
- Reset state: rst pulse, then flick=0 for 100 cycles -> lamps=0, busy=0, done=0 throughout.
- Full run (macro on): 1-cycle flick pulse in IDLE -> level walks 0..6..0..11..5..16..0, each value held 4 cycles, then lamps=16'hFFFF for 4 cycles, then done pulse. IDLE is reached 232 cycles after UP1 entry.
- Kickback at HI1: flick held high through UP2 -> every tick with level==6 drops to 5 in DOWN1. The bar oscillates 0..6 while flick stays high, and resumes to 11 after flick drops.
- Kickback in UP3 at HI2: flick=1 only on the UP3 tick with level==11 -> level 10, state DOWN2, falls to 5, rises again. No effect if flick pulses off-tick.
- Async reset mid-sweep: rst asserted between edges at level==9 -> lamps=0, busy=0 before the next clk edge. With TICK_DIV=1, a restart steps every cycle.
- Macro off: full run -> no all-ones frame, done 228 cycles after UP1 entry.
